// File: rtl/lcg_stream_pkg.sv
// lcg_stream_pkg
// Shared definitions for the lcg_stream LCG engine and its modular reducer:
//   - lcg_state_e : engine sequencing states (IDLE, MUL, RED, OUT)
//   - red_cycles  : number of bit-serial reduction steps for a given width
//   - lcg_latency : seed-to-first-output latency for a given width (serial path)
// No ports; imported by lcg_mod_reduce and lcg_stream.
package lcg_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RED  = 2'd2,
        OUT  = 2'd3
    } lcg_state_e;

    // The product A*X+C is 2W+1 bits wide and the reducer consumes one bit
    // of it per cycle, most significant first.
    function automatic int red_cycles(input int w);
        return 2 * w + 1;
    endfunction

    // Seed latch edge, one MUL cycle, then red_cycles() RED cycles.
    function automatic int lcg_latency(input int w);
        return 2 * w + 3;
    endfunction

    localparam int LCG_DEFAULT_W = 32;
    localparam int LCG_LATENCY   = lcg_latency(LCG_DEFAULT_W);

endpackage

// File: rtl/lcg_mod_reduce.sv
// lcg_mod_reduce
// Bit-serial restoring reducer: computes p_i mod mod_i, one product bit per
// cycle, MSB first. Owns its bit index counter.
// Ports:
//   CLK, RST_N  clock and asynchronous active-low reset
//   start_i     load R=0 and index=2W; stepping begins on the following cycle
//   p_i         2W+1 bit dividend, must be stable while stepping
//   mod_i       W+1 bit modulus M' (1 .. 2^W)
//   done_o      high during the cycle that processes bit 0
//   r_o         remainder after the current step (final result when done_o)
module lcg_mod_reduce
    import lcg_stream_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           start_i,
    input  logic [2*W:0]   p_i,
    input  logic [W:0]     mod_i,
    output logic           done_o,
    output logic [W-1:0]   r_o
);

    localparam int IDX_W = $clog2(red_cycles(W));
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(red_cycles(W) - 1);

    // The remainder is always below M' <= 2^W, so W bits hold it; only the
    // shifted intermediate needs the extra bit.
    logic [W-1:0]     r_q, r_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             active_q, active_d;
    logic [W:0]       r_shift;
    logic [W-1:0]     r_step;

    // One restoring step: bring in the next product bit and subtract M'
    // once if the partial remainder reached it (it is always below 2*M').
    always_comb begin
        r_shift = {r_q, p_i[idx_q]};
        r_step  = (r_shift >= mod_i) ? W'(r_shift - mod_i) : r_shift[W-1:0];
    end

    // Step sequencing: start reloads the counter, each active cycle consumes
    // one bit and the cycle on bit 0 ends the run.
    always_comb begin
        r_d      = r_q;
        idx_d    = idx_q;
        active_d = active_q;
        if (start_i) begin
            r_d      = '0;
            idx_d    = IDX_TOP;
            active_d = 1'b1;
        end else if (active_q) begin
            r_d = r_step;
            if (idx_q == '0) begin
                active_d = 1'b0;
            end else begin
                idx_d = idx_q - IDX_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_q      <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else begin
            r_q      <= r_d;
            idx_q    <= idx_d;
            active_q <= active_d;
        end
    end

    assign done_o = active_q && (idx_q == '0);
    assign r_o    = r_step;

endmodule

// File: rtl/lcg_stream.sv
// lcg_stream
// Linear congruential generator X(n+1) = (A*X(n) + C) mod M with run-time
// A, C, M (M = 0 means 2^W) and a valid/ready output stream.
// Optional feature macro: LCG_STREAM_POW2_FAST_EN -- when defined, a modulus
// of 0 or a power of two skips the serial reducer (masking in MUL instead).
// Ports:
//   CLK, RST_N           clock and asynchronous active-low reset
//   seed_valid           load seed and config, always accepted, overrides all
//   seed, cfg_mult,
//   cfg_inc, cfg_mod     X(0), A, C, M
//   out_valid/out_ready  output handshake, out_value held until accepted
//   out_value            current generated value
//   busy                 high in MUL and RED
//   gen_count            handshakes since the last seed (wrapping)
module lcg_stream
    import lcg_stream_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             seed_valid,
    input  logic [W-1:0]     seed,
    input  logic [W-1:0]     cfg_mult,
    input  logic [W-1:0]     cfg_inc,
    input  logic [W-1:0]     cfg_mod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_value,
    output logic             busy,
    output logic [CNT_W-1:0] gen_count
);

    lcg_state_e       state_q, state_d;
    logic [W-1:0]     x_q, x_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     c_q, c_d;
    logic [W-1:0]     m_q, m_d;
    logic [2*W:0]     p_q, p_d;
    logic [W-1:0]     out_value_q, out_value_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] gen_count_q, gen_count_d;
`ifdef LCG_STREAM_POW2_FAST_EN
    logic             pow2_q, pow2_d;
`endif

    logic [2*W-1:0]   prod;
    logic [2*W:0]     p_full;
    logic [W:0]       mod_prime;
    logic             red_start;
    logic             red_done;
    logic [W-1:0]     red_r;

    // Full-width A*X+C so the reducer sees the exact value; M==0 stands
    // for 2^W, which needs the extra bit of M'.
    always_comb begin
        prod      = {{W{1'b0}}, a_q} * {{W{1'b0}}, x_q};
        p_full    = {1'b0, prod} + {{(W+1){1'b0}}, c_q};
        mod_prime = (m_q == '0) ? {1'b1, {W{1'b0}}} : {1'b0, m_q};
    end

    // Sequencing. A seed overrides everything, including a handshake in the
    // same cycle: the value is dropped and the count restarts at zero.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        a_d         = a_q;
        c_d         = c_q;
        m_d         = m_q;
        p_d         = p_q;
        out_value_d = out_value_q;
        out_valid_d = out_valid_q;
        gen_count_d = gen_count_q;
        red_start   = 1'b0;
`ifdef LCG_STREAM_POW2_FAST_EN
        pow2_d      = pow2_q;
`endif
        if (seed_valid) begin
            x_d         = seed;
            a_d         = cfg_mult;
            c_d         = cfg_inc;
            m_d         = cfg_mod;
            out_valid_d = 1'b0;
            gen_count_d = '0;
            state_d     = MUL;
`ifdef LCG_STREAM_POW2_FAST_EN
            pow2_d      = ((cfg_mod & (cfg_mod - W'(1))) == '0);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                MUL: begin
                    p_d = p_full;
`ifdef LCG_STREAM_POW2_FAST_EN
                    if (pow2_q) begin
                        out_value_d = p_full[W-1:0] & W'(mod_prime - 1'b1);
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end else begin
                        red_start = 1'b1;
                        state_d   = RED;
                    end
`else
                    red_start = 1'b1;
                    state_d   = RED;
`endif
                end
                RED: begin
                    if (red_done) begin
                        out_value_d = red_r;
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        x_d         = out_value_q;
                        gen_count_d = gen_count_q + CNT_W'(1);
                        out_valid_d = 1'b0;
                        state_d     = MUL;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            x_q         <= '0;
            a_q         <= '0;
            c_q         <= '0;
            m_q         <= '0;
            p_q         <= '0;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
            gen_count_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            a_q         <= a_d;
            c_q         <= c_d;
            m_q         <= m_d;
            p_q         <= p_d;
            out_value_q <= out_value_d;
            out_valid_q <= out_valid_d;
            gen_count_q <= gen_count_d;
        end
    end

`ifdef LCG_STREAM_POW2_FAST_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pow2_q <= 1'b0;
        end else begin
            pow2_q <= pow2_d;
        end
    end
`endif

    // The reducer is started while leaving MUL, so it loads R=0 on the same
    // edge that registers the product and then steps through all of RED.
    lcg_mod_reduce #(
        .W (W)
    ) u_reduce (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .start_i (red_start),
        .p_i     (p_q),
        .mod_i   (mod_prime),
        .done_o  (red_done),
        .r_o     (red_r)
    );

    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign gen_count = gen_count_q;
    assign busy      = (state_q == MUL) || (state_q == RED);

endmodule

// File: doc/lcg_stream.md
Name: lcg_stream

Overview:
- Parametrised linear congruential generator engine: X(n+1) = (A*X(n) + C) mod M.
- Width is generic; A, C and M are configurable at run time.
- Modulus is arbitrary, reduced by a bit-serial restoring reducer.
- Free-running output stream with a valid/ready handshake and a generation counter. It feeds the PRNG-guessing datapath.

Parameters:
- W, 32, datapath width of X, A, C, M.
- CNT_W, 32, width of the generated-value counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- seed_valid  in  1  load seed and config; always accepted (no ready).
- seed  in  W  initial X(0).
- cfg_mult  in  W  A.
- cfg_inc  in  W  C.
- cfg_mod  in  W  M; 0 means 2^W.
- out_valid  out  1  out_value holds X(n).
- out_ready  in  1  consumer accepts X(n).
- out_value  out  W  current generated value.
- busy  out  1  high while computing (states MUL and RED).
- gen_count  out  CNT_W  number of handshakes completed since last seed; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state = IDLE.
  - out_valid=0, out_value=0, busy=0, gen_count=0.
  - Internal X, A, C, M, product and remainder registers = 0.
- States: IDLE, MUL, RED, OUT.
- IDLE:
  - Waits for seed_valid.
  - On seed_valid, latch seed/cfg_* into X/A/C/M and go to MUL.
- MUL, 1 cycle:
  - P = A*X + C, computed at full width 2W+1 bits (no truncation).
  - Go to RED with remainder R = 0 and bit index = 2W.
- RED, exactly 2W+1 cycles:
  - Each cycle R = (R<<1) | P[idx].
  - If R >= M', subtract M'. M' = M, or 2^W when M==0.
  - R is W+1 bits wide.
  - After the last bit: out_value = R[W-1:0], out_valid=1, go to OUT.
- Latency: out_valid rises 2W+3 cycles after the edge sampling seed_valid; 67 cycles for W=32.
- OUT:
  - out_value and out_valid are held stable until out_ready.
  - On out_valid & out_ready: X = out_value, gen_count += 1, out_valid=0 next cycle, go to MUL.
  - Throughput: one value per 2W+3 cycles with out_ready held high.
- seed_valid in any state, including mid-RED or OUT, has priority:
  - Relatch seed and config, go to MUL, out_valid=0, gen_count=0.
- seed_valid together with an OUT handshake in the same cycle:
  - The handshake counts as consumed, but the seed still wins.
  - gen_count = 0, and the next value derives from the new seed.
- Config inputs are ignored except on seed_valid.
- M==1: all outputs are 0.
- seed >= M: allowed; the first output is still fully reduced.
- busy = (state==MUL || state==RED).

Optional Feature:
- Macro: LCG_STREAM_POW2_FAST_EN.
- Defined:
  - If latched M is 0 or a power of two, RED is skipped.
  - out_value = P & (M'-1) is registered in MUL.
  - out_valid rises 2 cycles after seed_valid; throughput is one value per 2 cycles.
  - Power-of-two detection ((M & (M-1))==0) is registered at seed latch.
- Undefined:
  - Every modulus uses the serial path with the 2W+3 latency.
  - Output values are identical either way; only timing differs.

Decomposition:
- Package lcg_stream_pkg:
  - state enum {IDLE, MUL, RED, OUT}.
  - Function red_cycles(W) = 2W+1.
  - Constant for the latency 2W+3.
- Sub-module lcg_mod_reduce:
  - Bit-serial restoring reducer.
  - Interface: start, P (2W+1 bits), M', done, R.
  - Owns the bit index counter.

Test Plan:
- Reset and basic step:
  - RST_N low mid-RED: all outputs 0 immediately; after release, state IDLE, out_valid stays 0.
  - Then seed=96, A=4001, C=60211, M=993441: out_value=444307 exactly 67 cycles later (W=32).
- Stream continuation:
  - Same config, out_ready=1.
  - Second value = 466569, gen_count = 1 then 2.
  - Gap between values = 67 cycles.
- Modulus 2^W (M=0), A=1664525, C=1013904223, seed=0:
  - Outputs 1013904223, then 1196435762.
  - With LCG_STREAM_POW2_FAST_EN: same values, 2-cycle spacing.
- Backpressure:
  - out_ready=0 for 20 cycles in OUT: out_value/out_valid stable, gen_count unchanged.
  - Release: exactly one handshake counted.
- Reseed collisions:
  - seed_valid mid-RED: old computation discarded; next output derives from new seed at full latency.
  - seed_valid in the same cycle as a handshake: gen_count=0, and the new-seed value follows.
- Edge moduli:
  - M=1: output 0.
  - seed=5000000 with M=993441, A=1, C=0: output 5000000 mod 993441 = 32795.
